// File: rtl/mc_controller_pkg.sv
// Shared opcodes, select encodings, FSM state type and control bundle for the
// 4-bit CPU multicycle controller.
package cpu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_DIV   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_STORE = 4'd11;
    localparam logic [3:0] OP_ADDI  = 4'd12;
    localparam logic [3:0] OP_SUBI  = 4'd13;
    localparam logic [3:0] OP_BEQ   = 4'd14;
    localparam logic [3:0] OP_B     = 4'd15;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_DIV_WAIT = 4'd7,
        S_ALUWB    = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMMWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] pc_src;
        logic       div_start;
    } ctrl_t;

    // First execution state reached from DECODE for a given opcode.
    function automatic state_t decode_target(input logic [3:0] op);
        state_t s;
        if (op <= OP_MUL)
            s = S_RTYPE_EX;
        else if (op == OP_LOAD || op == OP_STORE)
            s = S_MEMADR;
        else if (op == OP_ADDI || op == OP_SUBI)
            s = S_IMM_EX;
        else if (op == OP_BEQ)
            s = S_BRANCH;
        else
            s = S_JUMP;
        return s;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory/divider signal bundle. master is the
// controller side, slave the datapath side.
interface mc_controller_if;
    logic [3:0] op;
    logic       zero;
    logic       mem_ready;
    logic       div_done;

    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       div_start;
    logic       div_timeout;

    modport master (
        input  op, zero, mem_ready, div_done,
        output pc_en, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop, pc_src,
               div_start, div_timeout
    );

    modport slave (
        output op, zero, mem_ready, div_done,
        input  pc_en, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop, pc_src,
               div_start, div_timeout
    );
endinterface

// File: rtl/mc_controller_div_watchdog.sv
// Divide watchdog: counts cycles spent waiting on the divider and flags the
// last allowed cycle.
module div_watchdog #(
    parameter int DIV_MAX_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else if (en)
            count_q <= count_q + CNT_W'(1);
    end

    assign expired = (count_q == CNT_W'(DIV_MAX_CYCLES - 1));

endmodule

// File: rtl/mc_controller.sv
// Multicycle main-control FSM for the 4-bit CPU: fetch/decode/execute/memory/
// writeback sequencing, memory and divider handshakes, divide watchdog.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  FETCH    0  | read instruction at PC, PC+1 when memory ready
//  DECODE   1  | register read, branch target precompute
//  MEMADR   2  | load/store address = A + imm
//  MEMRD    3  | data read, waits for mem_ready
//  MEMWB    4  | load result -> rt
//  MEMWR    5  | data write, waits for mem_ready
//  RTYPE_EX 6  | R-type ALU op; DIV launches the divider
//  DIV_WAIT 7  | wait for div_done, watchdog running
//  ALUWB    8  | ALUOut -> rd
//  IMM_EX   9  | A op imm
//  IMMWB   10  | ALUOut -> rt
//  BRANCH  11  | compare A,B; take branch on zero
//  JUMP    12  | PC <- jump target
module mc_controller
    import cpu_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_controller_if.master      bus,
    output logic [3:0]           state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctl;
    ctrl_t  ctl_out;
    logic   div_timeout_q;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_expired;

    assign wd_clr = (state_q == S_RTYPE_EX) && (bus.op == OP_DIV);
    assign wd_en  = (state_q == S_DIV_WAIT);

    div_watchdog #(
        .DIV_MAX_CYCLES (DIV_MAX_CYCLES),
        .CNT_W          (CNT_W)
    ) u_div_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_target(bus.op);
            S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = (bus.op == OP_DIV) ? S_DIV_WAIT : S_ALUWB;
            S_DIV_WAIT: begin
                // div_done takes priority over an expiry in the same cycle
                if (bus.div_done)
                    state_d = S_ALUWB;
                else if (wd_expired)
                    state_d = S_FETCH;
                else
                    state_d = S_DIV_WAIT;
            end
            S_ALUWB:    state_d = S_FETCH;
            S_IMM_EX:   state_d = S_IMMWB;
            S_IMMWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = ALUB_ONE;
                ctl.aluop     = ALUOP_ADD;
                ctl.pc_src    = PCSRC_ALU;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = ALUB_IMM;
                ctl.aluop     = ALUOP_ADD;
            end
            S_MEMADR, S_IMM_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_REG;
                ctl.aluop     = ALUOP_RTYPE;
                ctl.div_start = (bus.op == OP_DIV);
            end
            S_DIV_WAIT: begin
                ctl.aluop = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_IMMWB: begin
                ctl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_REG;
                ctl.aluop     = ALUOP_SUB;
                ctl.pc_src    = PCSRC_ALUOUT;
                ctl.pc_en     = bus.zero;
            end
            S_JUMP: begin
                ctl.pc_src = PCSRC_JUMP;
                ctl.pc_en  = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            div_timeout_q <= 1'b0;
        else if (state_q == S_DIV_WAIT && !bus.div_done && wd_expired)
            div_timeout_q <= 1'b1;
    end

    // No strobe may escape in the cycle reset is asserted, whatever the state.
    assign ctl_out = reset ? '0 : ctl;

    assign bus.pc_en       = ctl_out.pc_en;
    assign bus.ir_write    = ctl_out.ir_write;
    assign bus.iord        = ctl_out.iord;
    assign bus.mem_read    = ctl_out.mem_read;
    assign bus.mem_write   = ctl_out.mem_write;
    assign bus.reg_write   = ctl_out.reg_write;
    assign bus.reg_dst     = ctl_out.reg_dst;
    assign bus.mem_to_reg  = ctl_out.mem_to_reg;
    assign bus.alu_src_a   = ctl_out.alu_src_a;
    assign bus.alu_src_b   = ctl_out.alu_src_b;
    assign bus.aluop       = ctl_out.aluop;
    assign bus.pc_src      = ctl_out.pc_src;
    assign bus.div_start   = ctl_out.div_start;
    assign bus.div_timeout = div_timeout_q & ~reset;

    assign state_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected state traces built from
// the instruction-class rules, with randomised waits and don't-care inputs.
module tb_mc_controller;
    import cpu_pkg::*;

    localparam int DIV_MAX = 16;

    typedef struct {
        logic [3:0] s;
        logic       mr;
        logic       dd;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state_o;
    int         checks = 0;
    int         fails  = 0;
    logic       model_to = 1'b0;

    mc_controller_if io ();

    mc_controller #(
        .DIV_MAX_CYCLES (DIV_MAX),
        .CNT_W          (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (io.master),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // Expected strobes per state as listed in the controller's behaviour table.
    function automatic logic [17:0] exp_out(input logic [3:0] s, input logic mr,
                                            input logic z, input logic [3:0] opc,
                                            input logic to);
        logic pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst;
        logic mem_to_reg, asa, dstart;
        logic [1:0] asb, aop, psrc;
        {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst} = '0;
        {mem_to_reg, asa, dstart} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            4'd0:  begin mem_read = 1; asb = 2'b01; ir_write = mr; pc_en = mr; end
            4'd1:  asb = 2'b10;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mem_read = 1; iord = 1; end
            4'd4:  begin reg_write = 1; mem_to_reg = 1; end
            4'd5:  begin mem_write = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; dstart = (opc == 4'd8); end
            4'd7:  aop = 2'b10;
            4'd8:  begin reg_write = 1; reg_dst = 1; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: reg_write = 1;
            4'd11: begin asa = 1; aop = 2'b01; psrc = 2'b01; pc_en = z; end
            4'd12: begin psrc = 2'b10; pc_en = 1; end
            default: ;
        endcase
        return {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, asa, asb, aop, psrc, dstart, to};
    endfunction

    task automatic do_cycle(input logic [3:0] es, input logic mr, input logic dd,
                            input logic z, input logic rst, input logic [3:0] opc);
        logic [17:0] exp_v;
        logic [17:0] obs_v;
        logic [3:0]  exp_s;
        @(negedge clk);
        reset        = rst;
        io.mem_ready = mr;
        io.div_done  = dd;
        io.zero      = z;
        io.op        = opc;
        #1;
        exp_s = rst ? 4'd0 : es;
        exp_v = rst ? 18'd0 : exp_out(es, mr, z, opc, model_to);
        obs_v = {io.pc_en, io.ir_write, io.iord, io.mem_read, io.mem_write,
                 io.reg_write, io.reg_dst, io.mem_to_reg, io.alu_src_a,
                 io.alu_src_b, io.aluop, io.pc_src, io.div_start, io.div_timeout};
        checks++;
        assert (state_o === exp_s) else begin
            fails++;
            $error("FAIL state op=%0d: observed %0d expected %0d", opc, state_o, exp_s);
        end
        checks++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL outputs state=%0d op=%0d: observed %b expected %b",
                   exp_s, opc, obs_v, exp_v);
        end
        if (rst) model_to = 1'b0;
    endtask

    // dl = cycle of DIV_WAIT on which div_done arrives (1..DIV_MAX), else never.
    task automatic run_instr(input logic [3:0] opc, input int wf, input int wm,
                             input logic z, input int dl);
        step_t q[$];
        logic  timed_out = 1'b0;
        for (int k = 0; k < wf; k++) q.push_back('{4'd0, 1'b0, 1'($urandom_range(0, 1))});
        q.push_back('{4'd0, 1'b1, 1'($urandom_range(0, 1))});
        q.push_back('{4'd1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        if (opc <= 4'd9) begin
            q.push_back('{4'd6, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            if (opc == 4'd8) begin
                if (dl >= 1 && dl <= DIV_MAX) begin
                    for (int k = 0; k < dl - 1; k++)
                        q.push_back('{4'd7, 1'($urandom_range(0, 1)), 1'b0});
                    q.push_back('{4'd7, 1'($urandom_range(0, 1)), 1'b1});
                    q.push_back('{4'd8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
                end else begin
                    for (int k = 0; k < DIV_MAX; k++)
                        q.push_back('{4'd7, 1'($urandom_range(0, 1)), 1'b0});
                    timed_out = 1'b1;
                end
            end else begin
                q.push_back('{4'd8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            end
        end else if (opc == 4'd10) begin
            q.push_back('{4'd2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            for (int k = 0; k < wm; k++) q.push_back('{4'd3, 1'b0, 1'($urandom_range(0, 1))});
            q.push_back('{4'd3, 1'b1, 1'($urandom_range(0, 1))});
            q.push_back('{4'd4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        end else if (opc == 4'd11) begin
            q.push_back('{4'd2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            for (int k = 0; k < wm; k++) q.push_back('{4'd5, 1'b0, 1'($urandom_range(0, 1))});
            q.push_back('{4'd5, 1'b1, 1'($urandom_range(0, 1))});
        end else if (opc == 4'd12 || opc == 4'd13) begin
            q.push_back('{4'd9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            q.push_back('{4'd10, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        end else if (opc == 4'd14) begin
            q.push_back('{4'd11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        end else begin
            q.push_back('{4'd12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        end
        foreach (q[i]) do_cycle(q[i].s, q[i].mr, q[i].dd, z, 1'b0, opc);
        if (timed_out) model_to = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        io.op        = 4'd0;
        io.zero      = 1'b0;
        io.mem_ready = 1'b0;
        io.div_done  = 1'b0;
        do_cycle(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        do_cycle(4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);

        run_instr(4'd3, 0, 0, 1'b0, 0);          // ADD, no waits
        run_instr(4'd10, 2, 3, 1'b0, 0);         // LOAD with fetch and data waits
        run_instr(4'd14, 0, 0, 1'b1, 0);         // BEQ taken
        run_instr(4'd14, 1, 0, 1'b0, 0);         // BEQ not taken
        run_instr(4'd8, 0, 0, 1'b0, 5);          // DIV done after 5 wait cycles
        run_instr(4'd8, 0, 0, 1'b0, DIV_MAX);    // done on the expiry cycle wins
        run_instr(4'd8, 0, 0, 1'b0, 0);          // DIV never completes
        run_instr(4'd3, 1, 0, 1'b0, 0);          // flag persists
        run_instr(4'd15, 0, 0, 1'b0, 0);
        run_instr(4'd11, 2, 2, 1'b0, 0);
        do_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);

        for (int n = 0; n < 60; n++) begin
            int dl;
            dl = int'($urandom_range(0, 20));
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dl);
        end

        // Reset while a store is stalled on memory.
        do_cycle(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11);
        do_cycle(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);
        do_cycle(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);
        do_cycle(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);
        do_cycle(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);
        do_cycle(4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11);
        do_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);

        // Unused state codes must fall back to FETCH.
        for (int k = 13; k <= 15; k++) begin
            @(negedge clk);
            reset        = 1'b0;
            io.mem_ready = 1'b0;
            force dut.state_q = state_t'(4'(k));
            #1;
            checks++;
            assert (state_o === 4'(k)) else begin
                fails++;
                $error("FAIL illegal_state_hold: observed %0d expected %0d", state_o, k);
            end
            checks++;
            assert ({io.mem_read, io.mem_write, io.reg_write, io.pc_en, io.div_start} === 5'b0) else begin
                fails++;
                $error("FAIL illegal_state_strobes: observed %b expected 00000",
                       {io.mem_read, io.mem_write, io.reg_write, io.pc_en, io.div_start});
            end
            release dut.state_q;
            do_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main-control FSM for the 4-bit CPU. Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Drives the 2-bit aluop consumed by the ALU decoder, plus all datapath mux and enable strobes.
- Handshakes with instruction/data memory (mem_ready) and with an iterative divider (div_start/div_done).
- Includes a watchdog that aborts a stuck divide.

Parameters:
- DIV_MAX_CYCLES, 16, maximum cycles spent in DIV_WAIT before the divide is aborted.
- CNT_W, 5, width of the divide watchdog counter; must satisfy 2^CNT_W > DIV_MAX_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  4  opcode from the instruction register (0-9 R-type, 10-14 I-type, 15 B).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- div_done  in  1  divider result valid (single-cycle pulse or level).
- pc_en  out  1  PC register load enable.
- ir_write  out  1  instruction register load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback select: 1 = memory data register, 0 = ALUOut.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = constant 1, 10 = sign-extended immediate.
- aluop  out  2  00 = add (SUBI subtracts), 01 = sub (BEQ), 10 = R-type per op.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- div_start  out  1  one-cycle divider launch.
- div_timeout  out  1  sticky abort flag; cleared only by reset.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM. Outputs decode from the state register, except those noted as mem_ready- or zero-gated. All outputs are 0 when not listed.
- Reset:
  - state = FETCH, watchdog count = 0, div_timeout = 0.
  - All outputs are forced 0 during the reset cycle, including mem_read.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, DIV_WAIT=7, ALUWB=8, IMM_EX=9, IMMWB=10, BRANCH=11, JUMP=12. Codes 13-15 go to FETCH on the next cycle.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, aluop = 00, pc_src = 00.
  - ir_write and pc_en equal mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 10, aluop = 00 (branch target precompute).
  - op 0-9 -> RTYPE_EX; 10 or 11 -> MEMADR; 12 or 13 -> IMM_EX; 14 -> BRANCH; 15 -> JUMP.
- MEMADR:
  - alu_src_a = 1, alu_src_b = 10, aluop = 00.
  - LOAD -> MEMRD; STORE -> MEMWR.
- MEMRD: mem_read = 1, iord = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEMWR: mem_write = 1, iord = 1. Holds until mem_ready, then goes to FETCH. mem_write stays asserted for every held cycle.
- RTYPE_EX:
  - alu_src_a = 1, alu_src_b = 00, aluop = 10.
  - If op == DIV (8): div_start = 1 for exactly this cycle, watchdog cleared, next state DIV_WAIT.
  - Otherwise next state ALUWB.
- DIV_WAIT:
  - aluop = 10 held.
  - Watchdog increments each cycle.
  - If div_done = 1: go to ALUWB. div_done is tested before the timeout, so it wins when both occur in the same cycle.
  - Else if count == DIV_MAX_CYCLES-1: div_timeout <= 1, go to FETCH with no writeback.
  - div_done sampled in any other state is ignored.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- IMM_EX: alu_src_a = 1, alu_src_b = 10, aluop = 00. Goes to IMMWB.
- IMMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, aluop = 01, pc_src = 01.
  - pc_en = zero.
  - Goes to FETCH.
- JUMP: pc_src = 10, pc_en = 1. Goes to FETCH.
- Cycle counts with zero memory wait:
  - R-type 4.
  - ADDI/SUBI 4.
  - LOAD 5.
  - STORE 4.
  - BEQ 3.
  - B 3.
  - DIV is 4 + N cycles, where N is the number of DIV_WAIT cycles.
- Reset asserted mid-instruction (including during DIV_WAIT or a memory wait) returns to FETCH on the next edge. No partial write strobes are issued in that cycle.

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants (AND=0 … B=15).
  - aluop constants (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10).
  - state_t enum (4-bit).
  - alu_src_b and pc_src select constants.
- One natural sub-module, div_watchdog: counter with clear, enable and expired outputs, parameterised by DIV_MAX_CYCLES.

Test Plan:
- Reset, then op = ADD (3) with mem_ready tied 1 -> states 0,1,6,8,0. aluop = 10 in RTYPE_EX; reg_write = 1 with reg_dst = 1 in ALUWB only; pc_en = 1 in FETCH only.
- op = LOAD (10), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> FETCH held 3 cycles, with ir_write/pc_en high only in the last one. MEMRD held 4 cycles with iord = 1. MEMWB asserts reg_write = 1 and mem_to_reg = 1.
- op = BEQ (14) with zero = 1, then again with zero = 0 -> in BRANCH, aluop = 01 and pc_src = 01; pc_en = 1 and 0 respectively.
- op = DIV (8), div_done pulsed 5 cycles after div_start -> div_start high exactly 1 cycle. DIV_WAIT lasts 5 cycles, then ALUWB; div_timeout stays 0.
- op = DIV, div_done never asserted -> after 16 DIV_WAIT cycles, FETCH with no reg_write and div_timeout = 1. The flag persists through a following ADD and clears only on reset.
- Reset asserted during MEMWR with mem_ready = 0 -> next cycle state_o = 0 and mem_write = 0. Also force state code 13-15 through reset-free wraparound coverage and check the FSM returns to FETCH.
